// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage RV32 pipeline.
// Merges load-use (ID vs EX), taken branch (EX), MUL/DIV occupancy (EX) and
// data-memory wait states (MEM) into one set of stage-register enables,
// bubble inserts and flushes. Outputs are Mealy: combinational from state and inputs.
// Optional feature macro: MEM_TIMEOUT_EN adds a sticky dmem timeout flag.
// Handshake: dmem_req/dmem_ready behave as a valid/ready pair. An access
// completes on the cycle both are 1. Every cycle with dmem_req=1 and
// dmem_ready=0 freezes the whole pipeline.
// dbg_state exposes the FSM state: 0=RUN, 1=MDU_BUSY, 2=MEM_WAIT.
module pipeline_stall_ctrl #(
    parameter int MDU_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rd,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic       ex_is_mdu,
    input  logic       branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_bubble,
    output logic       ex_mem_write,
    output logic       ex_mem_bubble,
    output logic       mem_wb_write,
    output logic       mdu_start,
    output logic       mdu_hold,
    output logic       mem_timeout_err,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MDU_BUSY = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    // The entry cycle and the release cycle are both part of the EX
    // occupancy, so the countdown covers the cycles in between.
    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);

    // Parameter legality is checked at elaboration time.
    if (MDU_CYCLES < 2 || MDU_CYCLES > 15) begin : g_bad_mdu_cycles
        $error("MDU_CYCLES must be within 2..15");
    end
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 31) begin : g_bad_mem_timeout
        $error("MEM_TIMEOUT must be within 1..31");
    end

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q, ret_d;
    logic [1:0] eff_state;
    logic [3:0] cnt_q, cnt_d;
    logic       freeze;
    logic       load_use;
    logic       timeout_flag;

    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c, id_ex_bubble_c;
    logic ex_mem_write_c, ex_mem_bubble_c, mem_wb_write_c, mdu_start_c, mdu_hold_c;

    assign freeze   = dmem_req & ~dmem_ready;
    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    // Once the memory wait ends, the cycle is handled as the interrupted state.
    assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    // Resolve event priority (freeze > MDU busy > branch > load-use) into controls and next state.
    always_comb begin
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_write_c   = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_write_c  = 1'b1;
        ex_mem_bubble_c = 1'b0;
        mem_wb_write_c  = 1'b1;
        mdu_start_c     = 1'b0;
        mdu_hold_c      = 1'b0;
        state_d         = state_q;
        ret_d           = ret_q;
        cnt_d           = cnt_q;

        if (freeze) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_write_c  = 1'b0;
            ex_mem_write_c = 1'b0;
            mem_wb_write_c = 1'b0;
            mdu_hold_c     = 1'b1;
            state_d        = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_d = (state_q == ST_MDU_BUSY) ? ST_MDU_BUSY : ST_RUN;
            end
        end else if (eff_state == ST_MDU_BUSY) begin
            if (cnt_q == 4'd0) begin
                // Release: the MDU result advances into EX/MEM this cycle.
                state_d = ST_RUN;
            end else begin
                pc_write_c      = 1'b0;
                if_id_write_c   = 1'b0;
                id_ex_write_c   = 1'b0;
                ex_mem_bubble_c = 1'b1;
                cnt_d           = cnt_q - 4'd1;
                state_d         = ST_MDU_BUSY;
            end
        end else begin
            state_d = ST_RUN;
            if (ex_is_mdu) begin
                mdu_start_c     = 1'b1;
                pc_write_c      = 1'b0;
                if_id_write_c   = 1'b0;
                id_ex_write_c   = 1'b0;
                ex_mem_bubble_c = 1'b1;
                cnt_d           = MDU_LOAD;
                state_d         = ST_MDU_BUSY;
            end else if (branch_taken) begin
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
            end else if (load_use) begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
            end
        end
    end

    // FSM state, return state and MDU countdown registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [4:0] WAIT_LIMIT = 5'(MEM_TIMEOUT);

    logic [4:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;

    // Count consecutive frozen cycles (saturating) and latch the sticky timeout flag.
    always_comb begin
        wcnt_d = 5'd0;
        if (freeze) begin
            wcnt_d = (wcnt_q == WAIT_LIMIT) ? wcnt_q : wcnt_q + 5'd1;
        end
        err_d = err_q | (wcnt_d == WAIT_LIMIT);
    end

    // Wait counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= 5'd0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign timeout_flag = err_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // Every output reads 0 while reset is held.
    assign pc_write        = rst_n & pc_write_c;
    assign if_id_write     = rst_n & if_id_write_c;
    assign if_id_flush     = rst_n & if_id_flush_c;
    assign id_ex_write     = rst_n & id_ex_write_c;
    assign id_ex_bubble    = rst_n & id_ex_bubble_c;
    assign ex_mem_write    = rst_n & ex_mem_write_c;
    assign ex_mem_bubble   = rst_n & ex_mem_bubble_c;
    assign mem_wb_write    = rst_n & mem_wb_write_c;
    assign mdu_start       = rst_n & mdu_start_c;
    assign mdu_hold        = rst_n & mdu_hold_c;
    assign mem_timeout_err = rst_n & timeout_flag;
    assign dbg_state       = rst_n ? state_q : ST_RUN;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed bench for pipeline_stall_ctrl with a
// cycle-level reference model, an expected-value queue and a final report.
module tb_pipeline_stall_ctrl;

    localparam int MDU_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int W           = 13;
`ifdef MEM_TIMEOUT_EN
    localparam logic TO_ON = 1'b1;
`else
    localparam logic TO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_ex_memread = 1'b0;
    logic [4:0] id_ex_rd = 5'd0;
    logic [4:0] if_id_rs1 = 5'd0;
    logic [4:0] if_id_rs2 = 5'd0;
    logic       ex_is_mdu = 1'b0;
    logic       branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;

    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_write, ex_mem_bubble, mem_wb_write, mdu_start, mdu_hold;
    logic mem_timeout_err;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    // Model state: mode 0=RUN 1=MDU busy 2=memory wait; used counts unfrozen EX cycles of the MDU op.
    int m_mode = 0;
    int m_ret  = 0;
    int m_used = 0;
    int m_wait_run = 0;
    bit m_err = 1'b0;

    pipeline_stall_ctrl #(
        .MDU_CYCLES (MDU_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_ex_memread  (id_ex_memread),
        .id_ex_rd       (id_ex_rd),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .ex_is_mdu      (ex_is_mdu),
        .branch_taken   (branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_bubble  (ex_mem_bubble),
        .mem_wb_write   (mem_wb_write),
        .mdu_start      (mdu_start),
        .mdu_hold       (mdu_hold),
        .mem_timeout_err(mem_timeout_err),
        .dbg_state      (dbg_state)
    );

    // Clock: 10 time-unit period.
    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected outputs for the current inputs, then advance model state.
    task automatic model_step(output logic [W-1:0] e);
        bit pc, ifw, fl, idw, idb, exw, exb, mwb, st, hd, er, frz, haz;
        int dbg, eff;
        if (!rst_n) begin
            e = '0;
            m_mode = 0; m_ret = 0; m_used = 0; m_wait_run = 0; m_err = 1'b0;
            return;
        end
        pc = 1; ifw = 1; fl = 0; idw = 1; idb = 0; exw = 1; exb = 0; mwb = 1; st = 0; hd = 0;
        er  = m_err;
        dbg = m_mode;
        frz = dmem_req && !dmem_ready;
        haz = id_ex_memread && (id_ex_rd != 0) &&
              ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
        if (frz) begin
            pc = 0; ifw = 0; idw = 0; exw = 0; mwb = 0; hd = 1;
            if (m_mode != 2) m_ret = m_mode;
            m_mode = 2;
            m_wait_run++;
            if (TO_ON && m_wait_run >= MEM_TIMEOUT) m_err = 1'b1;
        end else begin
            m_wait_run = 0;
            eff = (m_mode == 2) ? m_ret : m_mode;
            if (eff == 1) begin
                m_used++;
                if (m_used >= MDU_CYCLES) begin
                    m_mode = 0;
                end else begin
                    pc = 0; ifw = 0; idw = 0; exb = 1; m_mode = 1;
                end
            end else if (ex_is_mdu) begin
                st = 1; pc = 0; ifw = 0; idw = 0; exb = 1;
                m_used = 1; m_mode = 1;
            end else begin
                m_mode = 0;
                if (branch_taken) begin
                    fl = 1; idb = 1;
                end else if (haz) begin
                    pc = 0; ifw = 0; idb = 1;
                end
            end
        end
        e = {pc, ifw, fl, idw, idb, exw, exb, mwb, st, hd, er, 2'(dbg)};
    endtask

    // Driver: apply one cycle of inputs after the edge, queue the expectation, return past the sample point.
    task automatic drive(input bit rst, input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input bit mdu, input bit br, input bit dq,
                         input bit dr, input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        rst_n = rst; id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = r1; if_id_rs2 = r2;
        ex_is_mdu = mdu; branch_taken = br; dmem_req = dq; dmem_ready = dr;
        model_step(e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, tag);
    endtask

    // Hand-computed literal check.
    task automatic lit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    // Scoreboard: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        string        t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write,
                   ex_mem_bubble, mem_wb_write, mdu_start, mdu_hold, mem_timeout_err, dbg_state};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL model_%s cyc=%0d got=%b exp=%b", t, cyc, got, e);
            end
        end
    end

    initial begin
        // Reset state.
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "rst0");
        lit("rst_pc_write", pc_write, 1'b0);
        lit("rst_mem_wb_write", mem_wb_write, 1'b0);
        drive(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 1, 0, "rst1");
        lit("rst_all_zero", ({pc_write, if_id_write, id_ex_write, ex_mem_write, mdu_hold, mdu_start} == 6'd0), 1'b1);
        idle("post_rst");
        lit("post_rst_pc", pc_write, 1'b1);
        lit("post_rst_state", (dbg_state == 2'd0), 1'b1);

        // Load-use hazards.
        drive(1, 1, 5'd10, 5'd10, 5'd0, 0, 0, 0, 0, "lu_rs1");
        lit("lu_pc_write", pc_write, 1'b0);
        lit("lu_if_id_write", if_id_write, 1'b0);
        lit("lu_id_ex_bubble", id_ex_bubble, 1'b1);
        idle("lu_after");
        lit("lu_after_pc", pc_write, 1'b1);
        drive(1, 1, 5'd10, 5'd0, 5'd10, 0, 0, 0, 0, "lu_rs2");
        lit("lu_rs2_bubble", id_ex_bubble, 1'b1);
        drive(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "lu_x0");
        lit("lu_x0_pc", pc_write, 1'b1);
        lit("lu_x0_bubble", id_ex_bubble, 1'b0);
        drive(1, 1, 5'd5, 5'd6, 5'd7, 0, 0, 0, 0, "lu_miss");
        drive(1, 0, 5'd6, 5'd6, 5'd6, 0, 0, 0, 0, "lu_noload");

        // MUL/DIV occupancy: stall T..T+2, release at T+3.
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "mdu_t0");
        lit("mdu_t0_start", mdu_start, 1'b1);
        lit("mdu_t0_idw", id_ex_write, 1'b0);
        lit("mdu_t0_exb", ex_mem_bubble, 1'b1);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, "mdu_t1_br");
        lit("mdu_t1_start", mdu_start, 1'b0);
        lit("mdu_t1_br_ignored", if_id_flush, 1'b0);
        lit("mdu_t1_idw", id_ex_write, 1'b0);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "mdu_t2");
        lit("mdu_t2_exb", ex_mem_bubble, 1'b1);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "mdu_t3");
        lit("mdu_rel_idw", id_ex_write, 1'b1);
        lit("mdu_rel_exb", ex_mem_bubble, 1'b0);
        lit("mdu_rel_start", mdu_start, 1'b0);
        idle("mdu_done");

        // Branch overrides load-use.
        drive(1, 1, 5'd10, 5'd10, 5'd0, 0, 1, 0, 0, "br_lu");
        lit("br_flush", if_id_flush, 1'b1);
        lit("br_bubble", id_ex_bubble, 1'b1);
        lit("br_pc", pc_write, 1'b1);
        lit("br_if_id_write", if_id_write, 1'b1);

        // Freeze inside MDU busy: counter holds, two stalled cycles after ready.
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "fz_start");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, "fz_wait");
            lit("fz_writes", ({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} == 5'd0), 1'b1);
            lit("fz_hold", mdu_hold, 1'b1);
        end
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, "fz_ready");
        lit("fz_ready_idw", id_ex_write, 1'b0);
        lit("fz_ready_hold", mdu_hold, 1'b0);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "fz_busy2");
        lit("fz_busy2_idw", id_ex_write, 1'b0);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "fz_release");
        lit("fz_release_idw", id_ex_write, 1'b1);
        idle("fz_done");

        // Freeze in RUN delays the MDU start until ready.
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, "fr_wait0");
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, "fr_wait1");
        lit("fr_no_start", mdu_start, 1'b0);
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, "fr_ready");
        lit("fr_start", mdu_start, 1'b1);
        for (int i = 0; i < 3; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "fr_busy");
        lit("fr_release", id_ex_write, 1'b1);
        idle("fr_done");

        // Long memory wait: timeout flag after MEM_TIMEOUT frozen cycles when enabled.
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "to_wait");
            if (i == MEM_TIMEOUT - 1) lit("to_not_yet", mem_timeout_err, 1'b0);
        end
        drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, "to_ready");
        lit("to_err_set", mem_timeout_err, TO_ON);
        idle("to_sticky");
        lit("to_err_sticky", mem_timeout_err, TO_ON);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, "to_rst");
        lit("to_rst_clear", mem_timeout_err, 1'b0);
        idle("to_after_rst");
        lit("to_after_rst", mem_timeout_err, 1'b0);

        // Reset during MDU busy abandons the op.
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "r6_start");
        drive(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "r6_busy");
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "r6_rst");
        lit("r6_rst_zero", ({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, ex_mem_bubble, mdu_start} == 7'd0), 1'b1);
        idle("r6_run");
        lit("r6_run_idw", id_ex_write, 1'b1);
        lit("r6_run_exb", ex_mem_bubble, 1'b0);
        lit("r6_run_state", (dbg_state == 2'd0), 1'b1);

        // Mixed tail checked by the model alone.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), "mix");
        end
        idle("final");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
